hack_cpu_ctrl: RTL

Multi-cycle Hack CPU core. It fetches 16-bit Hack instructions, decodes them into the six ALU control bits, and drives the team's existing `ALU`. It uses the ALU's `zr`/`ng` flags for jump resolution and commits results to the A, D and PC registers and to data memory. It sits between the instruction ROM / data RAM ports and the ALU, and uses req/ack handshakes on both memories so slow memories can stall it.

---
 rtl/hack_pkg.sv | 49 ++++
 rtl/ALU.sv | 34 +++
 rtl/hack_cpu_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU controller: FSM states, instruction
// field positions, destination/jump masks and the jump-condition helper.
package hack_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 15;

    // Instruction field positions
    localparam int CI_BIT  = 15;   // 1 = C-instruction, 0 = A-instruction
    localparam int A_BIT   = 12;   // selects M (memory) instead of A as ALU y
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_HI = 5;
    localparam int DEST_LO = 3;
    localparam int JUMP_HI = 2;
    localparam int JUMP_LO = 0;

    // Destination field masks (d1 d2 d3)
    localparam logic [2:0] DEST_A_MASK = 3'b100;
    localparam logic [2:0] DEST_D_MASK = 3'b010;
    localparam logic [2:0] DEST_M_MASK = 3'b001;

    // Jump field masks (j1 j2 j3)
    localparam logic [2:0] JUMP_LT_MASK = 3'b100;
    localparam logic [2:0] JUMP_EQ_MASK = 3'b010;
    localparam logic [2:0] JUMP_GT_MASK = 3'b001;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MREAD  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MWRITE = 3'd4
    } state_t;

    // Jump resolution from the ALU flags; 111 always jumps, 000 never does.
    function automatic logic jump_taken(input logic [2:0] jmp,
                                        input logic       zr,
                                        input logic       ng);
        logic lt;
        logic eq;
        logic gt;
        lt = (|(jmp & JUMP_LT_MASK)) & ng;
        eq = (|(jmp & JUMP_EQ_MASK)) & zr;
        gt = (|(jmp & JUMP_GT_MASK)) & ~ng & ~zr;
        return lt | eq | gt;
    endfunction

endpackage

// File: rtl/ALU.sv
// Hack ALU: purely combinational, six control bits plus zero/negative flags.
module ALU (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z;
    logic [15:0] x_n;
    logic [15:0] y_z;
    logic [15:0] y_n;
    logic [15:0] f_out;

    // Zero/negate inputs, add or AND, optionally negate result, derive flags
    always_comb begin
        x_z   = zx ? 16'h0000 : x;
        x_n   = nx ? ~x_z : x_z;
        y_z   = zy ? 16'h0000 : y;
        y_n   = ny ? ~y_z : y_z;
        f_out = f ? (x_n + y_n) : (x_n & y_n);
        out   = no ? ~f_out : f_out;
        zr    = (out == 16'h0000);
        ng    = out[15];
    end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU core: fetch over a req/ack instruction port, decode,
// optional data read, ALU execute with jump resolution, optional data write,
// then a single-edge commit to A, D and PC.
module hack_cpu_ctrl
    import hack_pkg::*;
#(
    parameter logic [14:0] RESET_PC = 15'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [14:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic [14:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic [14:0] pc,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg,
    output logic        instr_done
);

    state_t state_reg;
    state_t state_next;

    logic [WORD_W-1:0] ir_reg;
    logic [WORD_W-1:0] mdr_reg;
    logic [WORD_W-1:0] res_reg;
    logic              take_reg;
    logic [ADDR_W-1:0] pc_reg;

    logic imem_req_reg;
    logic imem_req_next;
    logic dmem_rd_reg;
    logic dmem_rd_next;
    logic dmem_wr_reg;
    logic dmem_wr_next;
    logic instr_done_reg;

    // Control strobes from the FSM
    logic              ir_load;
    logic              mdr_load;
    logic              res_load;
    logic              a_commit;
    logic              c_commit;
    logic [WORD_W-1:0] commit_val;
    logic              commit_take;

    // Decoded instruction fields
    logic [5:0] comp;
    logic [2:0] dest;
    logic [2:0] jmp;
    logic       dest_a;
    logic       dest_d;
    logic       dest_m;
    logic       is_cinstr;
    logic       use_m;

    // ALU datapath
    logic [WORD_W-1:0] alu_y;
    logic [WORD_W-1:0] alu_out;
    logic              alu_zr;
    logic              alu_ng;
    logic              take;

    assign comp      = ir_reg[COMP_HI:COMP_LO];
    assign dest      = ir_reg[DEST_HI:DEST_LO];
    assign jmp       = ir_reg[JUMP_HI:JUMP_LO];
    assign dest_a    = |(dest & DEST_A_MASK);
    assign dest_d    = |(dest & DEST_D_MASK);
    assign dest_m    = |(dest & DEST_M_MASK);
    assign is_cinstr = ir_reg[CI_BIT];
    assign use_m     = ir_reg[A_BIT];

    assign alu_y = use_m ? mdr_reg : a_reg;
    assign take  = jump_taken(jmp, alu_zr, alu_ng);

    ALU u_alu (
        .x   (d_reg),
        .y   (alu_y),
        .zx  (comp[5]),
        .nx  (comp[4]),
        .zy  (comp[3]),
        .ny  (comp[2]),
        .f   (comp[1]),
        .no  (comp[0]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    // Registered outputs; the data address tracks A, which only changes at commit
    assign imem_req   = imem_req_reg;
    assign imem_addr  = pc_reg;
    assign dmem_rd    = dmem_rd_reg;
    assign dmem_wr    = dmem_wr_reg;
    assign dmem_addr  = a_reg[ADDR_W-1:0];
    assign dmem_wdata = res_reg;
    assign pc         = pc_reg;
    assign instr_done = instr_done_reg;

    // Next-state, datapath load enables and the strobes for the next cycle
    always_comb begin
        state_next  = state_reg;
        ir_load     = 1'b0;
        mdr_load    = 1'b0;
        res_load    = 1'b0;
        a_commit    = 1'b0;
        c_commit    = 1'b0;
        commit_val  = alu_out;
        commit_take = take;

        case (state_reg)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_load    = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!is_cinstr) begin
                    a_commit   = 1'b1;
                    state_next = ST_FETCH;
                end else if (use_m) begin
                    state_next = ST_MREAD;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_MREAD: begin
                if (dmem_ack) begin
                    mdr_load   = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dest_m) begin
                    res_load   = 1'b1;
                    state_next = ST_MWRITE;
                end else begin
                    c_commit   = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_MWRITE: begin
                commit_val  = res_reg;
                commit_take = take_reg;
                if (dmem_ack) begin
                    c_commit   = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase

        // Strobes are registered, so they are derived from the upcoming state
        imem_req_next = (state_next == ST_FETCH);
        dmem_rd_next  = (state_next == ST_MREAD);
        dmem_wr_next  = (state_next == ST_MWRITE);
    end

    // FSM state and handshake strobes; reset drops data strobes at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_FETCH;
            imem_req_reg <= 1'b1;
            dmem_rd_reg  <= 1'b0;
            dmem_wr_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            imem_req_reg <= imem_req_next;
            dmem_rd_reg  <= dmem_rd_next;
            dmem_wr_reg  <= dmem_wr_next;
        end
    end

    // Internal holding registers: instruction, memory read data, write result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_reg   <= '0;
            mdr_reg  <= '0;
            res_reg  <= '0;
            take_reg <= 1'b0;
        end else begin
            if (ir_load) begin
                ir_reg <= imem_rdata;
            end
            if (mdr_load) begin
                mdr_reg <= dmem_rdata;
            end
            if (res_load) begin
                res_reg  <= alu_out;
                take_reg <= take;
            end
        end
    end

    // Architectural commit; jump target and every operand use pre-commit A
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg         <= RESET_PC;
            a_reg          <= '0;
            d_reg          <= '0;
            instr_done_reg <= 1'b0;
        end else begin
            instr_done_reg <= 1'b0;
            if (a_commit) begin
                a_reg          <= ir_reg;
                pc_reg         <= pc_reg + 15'd1;
                instr_done_reg <= 1'b1;
            end else if (c_commit) begin
                if (dest_a) begin
                    a_reg <= commit_val;
                end
                if (dest_d) begin
                    d_reg <= commit_val;
                end
                pc_reg         <= commit_take ? a_reg[ADDR_W-1:0] : pc_reg + 15'd1;
                instr_done_reg <= 1'b1;
            end
        end
    end

endmodule
